// File: rtl/time_setter.sv
// time_setter: two-button hour/minute setting FSM driving a register bank.
// Optional auto-repeat on a held Up button: define TIME_SETTER_AUTOREPEAT_EN.
module time_setter #(
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic       Mode_btn,
  input  logic       Up_btn,
  input  logic [4:0] Cur_hour,
  input  logic [5:0] Cur_min,
  output logic [4:0] Hour_D,
  output logic [5:0] Min_D,
  output logic       Hour_En,
  output logic       Min_En,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    COMMIT   = 2'b11
  } state_e;

  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("time_setter: REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  state_e     state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic       mode_q, mode_d;
  logic       up_q, up_d;
  logic       mode_rise;
  logic       up_rise;
  logic       up_inc;
  logic       in_set;

  assign mode_rise = Mode_btn & ~mode_q;
  assign up_rise   = Up_btn & ~up_q;
  assign in_set    = (state_q == SET_HOUR) || (state_q == SET_MIN);

`ifdef TIME_SETTER_AUTOREPEAT_EN
  localparam int MAXC = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] rpt_q, rpt_d;
  logic          rpt_fire;

  // Down-counter: loaded with the delay on a rise, reloaded with the rate on each repeat.
  // Mode wins over Up, so a Mode rise also cancels any repeat in progress.
  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if (in_set && Up_btn && !mode_rise) begin
      if (up_rise) begin
        rpt_d = CW'(REPEAT_DELAY);
      end else if (rpt_q == CW'(1)) begin
        rpt_fire = 1'b1;
        rpt_d    = CW'(REPEAT_RATE);
      end else if (rpt_q != '0) begin
        rpt_d = rpt_q - CW'(1);
      end
    end
  end

  // Repeat counter register.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end

  assign up_inc = up_rise | rpt_fire;
`else
  assign up_inc = up_rise;
`endif

  // Next-state, shadow update and button history.
  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    mode_d  = Mode_btn;
    up_d    = Up_btn;
    unique case (state_q)
      IDLE: begin
        if (mode_rise) begin
          hour_d  = Cur_hour;
          min_d   = Cur_min;
          state_d = SET_HOUR;
        end
      end
      SET_HOUR: begin
        if (mode_rise) begin
          state_d = SET_MIN;
        end else if (up_inc) begin
          hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
      end
      SET_MIN: begin
        if (mode_rise) begin
          state_d = COMMIT;
        end else if (up_inc) begin
          min_d = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shadow and button registers.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= IDLE;
      hour_q  <= '0;
      min_q   <= '0;
      mode_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      mode_q  <= mode_d;
      up_q    <= up_d;
    end
  end

  assign Hour_D  = hour_q;
  assign Min_D   = min_q;
  assign Hour_En = (state_q == COMMIT);
  assign Min_En  = (state_q == COMMIT);
  assign State   = state_q;

endmodule

// File: tb/tb_time_setter.sv
// tb_time_setter: directed scenarios plus randomized button traffic,
// checked against a cycle-level behavioural model of the setter.
module tb_time_setter;

  localparam int REP_D = 8;
  localparam int REP_R = 4;
`ifdef TIME_SETTER_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Clear;
  logic       Mode_btn;
  logic       Up_btn;
  logic [4:0] Cur_hour;
  logic [5:0] Cur_min;
  logic [4:0] Hour_D;
  logic [5:0] Min_D;
  logic       Hour_En;
  logic       Min_En;
  logic [1:0] State;

  int checks = 0;
  int errors = 0;

  // model: state 0..3, shadows, last button levels, cycles held since Up rise
  int m_st, m_h, m_m, m_n;
  bit m_pm, m_pu;

  time_setter #(.REPEAT_DELAY(REP_D), .REPEAT_RATE(REP_R)) dut (
    .Clock    (Clock),
    .Clear    (Clear),
    .Mode_btn (Mode_btn),
    .Up_btn   (Up_btn),
    .Cur_hour (Cur_hour),
    .Cur_min  (Cur_min),
    .Hour_D   (Hour_D),
    .Min_D    (Min_D),
    .Hour_En  (Hour_En),
    .Min_En   (Min_En),
    .State    (State)
  );

  always #5 Clock = ~Clock;

  task automatic model_reset();
    m_st = 0; m_h = 0; m_m = 0; m_n = -1;
    m_pm = 1'b0; m_pu = 1'b0;
  endtask

  task automatic model_step(input bit md, input bit up);
    bit mr, ur, inc, set;
    mr  = md && !m_pm;
    ur  = up && !m_pu;
    set = (m_st == 1) || (m_st == 2);
    if (set && up && !mr) m_n = ur ? 0 : ((m_n >= 0) ? m_n + 1 : -1);
    else                  m_n = -1;
    inc = (m_n == 0) ||
          (AUTO && m_n >= REP_D && ((m_n - REP_D) % REP_R) == 0);
    case (m_st)
      0: if (mr) begin m_h = int'(Cur_hour); m_m = int'(Cur_min); m_st = 1; end
      1: if (mr) m_st = 2; else if (inc) m_h = (m_h >= 23) ? 0 : m_h + 1;
      2: if (mr) m_st = 3; else if (inc) m_m = (m_m >= 59) ? 0 : m_m + 1;
      default: m_st = 0;
    endcase
    m_pm = md;
    m_pu = up;
  endtask

  task automatic cycle(input bit md, input bit up);
    Mode_btn = md;
    Up_btn   = up;
    @(posedge Clock);
    if (!Clear) model_step(md, up);
    #1;
  endtask

  task automatic press(input bit md, input bit up);
    cycle(md, up);
    cycle(1'b0, 1'b0);
  endtask

  // Enables must be high exactly while the model sits in its one COMMIT cycle.
  always @(negedge Clock) begin
    if (!Clear) begin
      checks++;
      if (Hour_En !== (m_st == 3) || Min_En !== (m_st == 3)) begin
        errors++;
        $display("FAIL enable_hygiene t=%0t Hour_En=%b Min_En=%b expected %b",
                 $time, Hour_En, Min_En, (m_st == 3));
      end
    end
  end

  task automatic test_reset();
    Clear = 1'b1;
    Mode_btn = 1'($urandom);
    Up_btn = 1'($urandom);
    Cur_hour = 5'($urandom);
    Cur_min = 6'($urandom);
    #1;
    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    checks++;
    if (State !== 2'b00 || Hour_D !== 5'd0 || Min_D !== 6'd0 ||
        Hour_En !== 1'b0 || Min_En !== 1'b0) begin
      errors++;
      $display("FAIL reset got st=%b h=%0d m=%0d en=%b%b want 00 0 0 00",
               State, Hour_D, Min_D, Hour_En, Min_En);
    end
    Mode_btn = 1'b0;
    Up_btn = 1'b0;
    Clear = 1'b0;
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_full_set();
    Cur_hour = 5'd10;
    Cur_min = 6'd30;
    cycle(1'b1, 1'b0);
    checks++;
    if (State !== 2'b01 || Hour_D !== 5'd10 || Min_D !== 6'd30) begin
      errors++;
      $display("FAIL full_capture got st=%b h=%0d m=%0d want 01 10 30",
               State, Hour_D, Min_D);
    end
    cycle(1'b0, 1'b0);
    repeat (3) press(1'b0, 1'b1);
    checks++;
    if (Hour_D !== 5'd13) begin
      errors++;
      $display("FAIL full_hour got %0d want 13", Hour_D);
    end
    press(1'b1, 1'b0);
    repeat (2) press(1'b0, 1'b1);
    checks++;
    if (State !== 2'b10 || Min_D !== 6'd32) begin
      errors++;
      $display("FAIL full_min got st=%b m=%0d want 10 32", State, Min_D);
    end
    cycle(1'b1, 1'b0);
    checks++;
    if (State !== 2'b11 || Hour_D !== 5'd13 || Min_D !== 6'd32 ||
        Hour_En !== 1'b1 || Min_En !== 1'b1) begin
      errors++;
      $display("FAIL full_commit got st=%b h=%0d m=%0d en=%b%b want 11 13 32 11",
               State, Hour_D, Min_D, Hour_En, Min_En);
    end
    cycle(1'b0, 1'b0);
    checks++;
    if (State !== 2'b00 || Hour_En !== 1'b0 || Hour_D !== 5'd13) begin
      errors++;
      $display("FAIL full_idle got st=%b en=%b h=%0d want 00 0 13",
               State, Hour_En, Hour_D);
    end
  endtask

  task automatic test_wrap();
    Cur_hour = 5'd23;
    Cur_min = 6'd59;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    checks++;
    if (State !== 2'b11 || Hour_D !== 5'd0 || Min_D !== 6'd0) begin
      errors++;
      $display("FAIL wrap_commit got st=%b h=%0d m=%0d want 11 0 0",
               State, Hour_D, Min_D);
    end
    cycle(1'b0, 1'b0);
    Cur_hour = 5'd30;
    Cur_min = 6'd63;
    press(1'b1, 1'b0);
    checks++;
    if (Hour_D !== 5'd30) begin
      errors++;
      $display("FAIL wrap_capture got %0d want 30", Hour_D);
    end
    press(1'b0, 1'b1);
    checks++;
    if (Hour_D !== 5'd0) begin
      errors++;
      $display("FAIL wrap_hour_oob got %0d want 0", Hour_D);
    end
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    checks++;
    if (Min_D !== 6'd0) begin
      errors++;
      $display("FAIL wrap_min_oob got %0d want 0", Min_D);
    end
    press(1'b1, 1'b0);
  endtask

  task automatic test_simultaneous();
    Cur_hour = 5'd5;
    Cur_min = 6'd40;
    press(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    checks++;
    if (State !== 2'b10 || Hour_D !== 5'd5) begin
      errors++;
      $display("FAIL simul got st=%b h=%0d want 10 5", State, Hour_D);
    end
    cycle(1'b0, 1'b0);
    press(1'b0, 1'b1);
    checks++;
    if (Min_D !== 6'd41) begin
      errors++;
      $display("FAIL simul_min got %0d want 41", Min_D);
    end
    press(1'b1, 1'b0);
  endtask

  task automatic test_held();
    Cur_hour = 5'd2;
    Cur_min = 6'd5;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    checks++;
`ifdef TIME_SETTER_AUTOREPEAT_EN
    if (Min_D !== 6'(m_m)) begin
      errors++;
      $display("FAIL held_repeat got %0d want %0d", Min_D, m_m);
    end
`else
    if (Min_D !== 6'd6) begin
      errors++;
      $display("FAIL held_single got %0d want 6", Min_D);
    end
`endif
    press(1'b1, 1'b0);
  endtask

  task automatic test_clear();
    Cur_hour = 5'd7;
    Cur_min = 6'd20;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    checks++;
    if (State !== 2'b10 || Hour_D !== 5'd7) begin
      errors++;
      $display("FAIL clear_setup got st=%b h=%0d want 10 7", State, Hour_D);
    end
    Clear = 1'b1;
    #1;
    model_reset();
    checks++;
    if (State !== 2'b00 || Hour_D !== 5'd0 || Min_D !== 6'd0 ||
        Hour_En !== 1'b0 || Min_En !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid got st=%b h=%0d m=%0d en=%b%b want 00 0 0 00",
               State, Hour_D, Min_D, Hour_En, Min_En);
    end
    Cur_hour = 5'd17;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    Clear = 1'b0;
    cycle(1'b1, 1'b0);
    checks++;
    if (State !== 2'b01 || Hour_D !== 5'd17) begin
      errors++;
      $display("FAIL clear_held_rise got st=%b h=%0d want 01 17", State, Hour_D);
    end
    cycle(1'b1, 1'b0);
    checks++;
    if (State !== 2'b01) begin
      errors++;
      $display("FAIL held_mode got st=%b want 01", State);
    end
    cycle(1'b0, 1'b0);
    press(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    Clear = 1'b1;
    #1;
    model_reset();
    checks++;
    if (State !== 2'b00 || Hour_En !== 1'b0 || Min_En !== 1'b0) begin
      errors++;
      $display("FAIL clear_commit got st=%b en=%b%b want 00 00",
               State, Hour_En, Min_En);
    end
    cycle(1'b0, 1'b0);
    Clear = 1'b0;
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit md, up;
    md = 1'b0;
    up = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        Cur_hour = 5'($urandom);
        Cur_min = 6'($urandom);
      end
      if ($urandom_range(0, 249) == 0) begin
        Clear = 1'b1;
        #1;
        model_reset();
        cycle(md, up);
        Clear = 1'b0;
      end
      if ($urandom_range(0, 9) < 3) md = ~md;
      if ($urandom_range(0, 9) < 2) up = ~up;
      cycle(md, up);
      checks++;
      if (State !== 2'(m_st) || Hour_D !== 5'(m_h) || Min_D !== 6'(m_m)) begin
        errors++;
        $display("FAIL random i=%0d got st=%b h=%0d m=%0d want %0d %0d %0d",
                 i, State, Hour_D, Min_D, m_st, m_h, m_m);
      end
    end
    Clear = 1'b1;
    #1;
    model_reset();
    cycle(1'b0, 1'b0);
    Clear = 1'b0;
  endtask

  initial begin
    Clear = 1'b1;
    Mode_btn = 1'b0;
    Up_btn = 1'b0;
    Cur_hour = '0;
    Cur_min = '0;
    model_reset();
    test_reset();
    test_full_set();
    test_wrap();
    test_simultaneous();
    test_held();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
